// File: rtl/fifo_rd_pkg.sv
// Shared types and defaults for the FIFO packet reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_rd_pkg;

    // Default FIFO word / stream width and header length-field width
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_LEN_W   = 8;

    // Length field sits in the low bits of the header word; upper bits are don't-care
    localparam int HDR_LEN_LSB = 0;

    typedef enum logic [1:0] {
        S_HDR   = 2'd0,
        S_HWAIT = 2'd1,
        S_PAY   = 2'd2
    } rd_state_t;

    // Buffer entry layout at the default width; the reader packs the same
    // {sop, eop, data} order at whatever DATA_W it is built with.
    typedef struct packed {
        logic                  sop;
        logic                  eop;
        logic [DEF_DATA_W-1:0] data;
    } buf_ent_t;

endpackage

// File: rtl/pkt_skid_buf.sv
// Two-entry output buffer feeding a valid/ready stream; exposes occupancy for read credit.
// Latency: a word written at edge E is presented on o_dat/o_vld right after E.
// Backpressure: holds up to 2 entries while i_rdy=0; writes to a full buffer without a pop are dropped.
module pkt_skid_buf #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_wr_vld,
    input  logic [W-1:0] i_wr_dat,
    output logic         o_vld,
    input  logic         i_rdy,
    output logic [W-1:0] o_dat,
    output logic [1:0]   o_occ
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_occ;

    logic         w_push;
    logic         w_pop;

    assign w_pop  = o_vld & i_rdy;
    assign w_push = i_wr_vld & ((r_occ != 2'd2) | w_pop);

    // Ring of two entries: write at r_wr_ptr, present r_rd_ptr, track fill level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wr_dat;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_vld = (r_occ != 2'd0);
    assign o_dat = r_mem[r_rd_ptr];
    assign o_occ = r_occ;

endmodule

// File: rtl/fifo_pkt_reader.sv
// Drains length-prefixed packets from a FIFO read port into a sop/eop valid/ready stream.
// Latency: header read at edge 0, decode at edge 1, first payload read at 2, m_valid from edge 3.
// Backpressure: payload reads only while buffered + in-flight words (net of this cycle's pop) < 2.
module fifo_pkt_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sop,
    output logic              m_eop,
    output logic [LEN_W-1:0]  m_len,
    output logic              err_len,
    output logic [15:0]       pkt_cnt
);

    localparam int               ENT_W   = DATA_W + 2;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    rd_state_t         r_state;
    logic [LEN_W-1:0]  r_rd_left;
    logic [LEN_W-1:0]  r_len;
    logic              r_first;
    logic              r_pay_if;
    logic              r_if_sop;
    logic              r_if_eop;
    logic              r_err;
    logic [15:0]       r_pkt_cnt;

    logic [1:0]        w_occ;
    logic              w_pop;
    logic [2:0]        w_used;
    logic              w_credit;
    logic              w_rd;
    logic [LEN_W-1:0]  w_hdr_len;
    logic [ENT_W-1:0]  w_wr_ent;
    logic [ENT_W-1:0]  w_hd_ent;

    assign w_hdr_len = fifo_data[HDR_LEN_LSB +: LEN_W];
    assign w_pop     = m_valid & m_ready;

    // A beat leaving this cycle frees its slot in time for the word a read now would return,
    // which is what sustains one beat per cycle with only two entries.
    assign w_used    = {1'b0, w_occ} - {2'b00, w_pop} + {2'b00, r_pay_if};
    assign w_credit  = (w_used < 3'd2);

    // Read strobe from state, FIFO flag and buffer credit; header reads need no credit
    always_comb begin
        w_rd = 1'b0;
        case (r_state)
            S_HDR:   w_rd = ~fifo_empty;
            S_PAY:   w_rd = ~fifo_empty & w_credit;
            default: w_rd = 1'b0;
        endcase
    end

    assign fifo_rd_en = w_rd & ~rst;

    // Packet FSM: header fetch, header decode, payload fetch with sop/eop tagging
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_HDR;
            r_rd_left <= '0;
            r_len     <= '0;
            r_first   <= 1'b0;
            r_pay_if  <= 1'b0;
            r_if_sop  <= 1'b0;
            r_if_eop  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_err    <= 1'b0;
            r_pay_if <= 1'b0;
            case (r_state)
                S_HDR: begin
                    if (w_rd) begin
                        r_state <= S_HWAIT;
                    end
                end
                S_HWAIT: begin
                    if (w_hdr_len == '0) begin
                        r_err   <= 1'b1;
                        r_state <= S_HDR;
                    end else begin
                        r_len     <= w_hdr_len;
                        r_rd_left <= w_hdr_len;
                        r_first   <= 1'b1;
                        r_state   <= S_PAY;
                    end
                end
                S_PAY: begin
                    if (w_rd) begin
                        r_pay_if  <= 1'b1;
                        r_if_sop  <= r_first;
                        r_if_eop  <= (r_rd_left == LEN_ONE);
                        r_first   <= 1'b0;
                        r_rd_left <= r_rd_left - LEN_ONE;
                        if (r_rd_left == LEN_ONE) begin
                            r_state <= S_HDR;
                        end
                    end
                end
                default: r_state <= S_HDR;
            endcase
        end
    end

    // Count packets as their eop beat is accepted downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_cnt <= 16'd0;
        end else if (w_pop & m_eop) begin
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
        end
    end

    assign w_wr_ent = {r_if_sop, r_if_eop, fifo_data};

    pkt_skid_buf #(
        .W (ENT_W)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .i_wr_vld (r_pay_if),
        .i_wr_dat (w_wr_ent),
        .o_vld    (m_valid),
        .i_rdy    (m_ready),
        .o_dat    (w_hd_ent),
        .o_occ    (w_occ)
    );

    assign m_sop   = w_hd_ent[ENT_W-1];
    assign m_eop   = w_hd_ent[ENT_W-2];
    assign m_data  = w_hd_ent[DATA_W-1:0];
    assign m_len   = r_len;
    assign err_len = r_err;
    assign pkt_cnt = r_pkt_cnt;

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Bench for fifo_pkt_reader: FIFO model, packet-level expected-beat scoreboard, directed tests.
// Latency: n/a.
// Backpressure: m_ready driven per test.
module tb_fifo_pkt_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_rd_en;
    logic [31:0] fifo_data = 32'd0;
    logic        fifo_empty = 1'b1;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic        m_sop;
    logic        m_eop;
    logic [7:0]  m_len;
    logic        err_len;
    logic [15:0] pkt_cnt;

    always #5 clk = ~clk;

    fifo_pkt_reader dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_sop      (m_sop),
        .m_eop      (m_eop),
        .m_len      (m_len),
        .err_len    (err_len),
        .pkt_cnt    (pkt_cnt)
    );

    logic [31:0] fq [$];
    logic [33:0] exp_q [$];
    int          hs_q [$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          rd_cnt = 0;
    int          err_seen = 0;
    logic [15:0] mdl_cnt = 16'd0;
    logic        prev_hold = 1'b0;
    logic [33:0] prev_beat = 34'd0;
    logic [33:0] e_beat;
    int          r0;
    int          e0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // FIFO model: a strobe at an edge pops the head, which appears on fifo_data after that edge
    always @(posedge clk) begin
        cyc++;
        if (fifo_rd_en) begin
            check("rd_nonempty", 64'(fq.size() != 0), 64'd1);
            rd_cnt++;
            if (fq.size() != 0) fifo_data <= fq.pop_front();
            fifo_empty <= (fq.size() == 0);
        end
    end

    // Stream monitor: compare each accepted beat with the packet model, hold rules, pkt_cnt
    always @(negedge clk) begin
        if (rst) begin
            mdl_cnt   = 16'd0;
            prev_hold = 1'b0;
        end else begin
            check("pkt_cnt_track", 64'(pkt_cnt), 64'(mdl_cnt));
            if (prev_hold) begin
                check("hold_valid", 64'(m_valid), 64'd1);
                check("hold_beat", 64'({m_sop, m_eop, m_data}), 64'(prev_beat));
            end
            if (err_len) err_seen++;
            if (m_valid && m_ready) begin
                hs_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'({m_sop, m_eop, m_data}), 64'h3_FFFF_FFFF_F);
                end else begin
                    e_beat = exp_q.pop_front();
                    check("beat", 64'({m_sop, m_eop, m_data}), 64'(e_beat));
                    if (e_beat[32]) mdl_cnt = mdl_cnt + 16'd1;
                end
            end
            prev_hold = m_valid && !m_ready;
            prev_beat = {m_sop, m_eop, m_data};
        end
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // Header + first n_now payload words go into the FIFO; all len beats are expected
    task automatic push_pkt(input int len, input logic [31:0] base, input int n_now);
        push_word(32'(len));
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({(i == 0), (i == len - 1), base + 32'(i)});
            if (i < n_now) push_word(base + 32'(i));
        end
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget && exp_q.size() != 0; k++) @(negedge clk);
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"},   64'(fifo_rd_en), 64'd0);
        check({tag, "_m_valid"}, 64'(m_valid),    64'd0);
        check({tag, "_m_data"},  64'(m_data),     64'd0);
        check({tag, "_m_sop"},   64'(m_sop),      64'd0);
        check({tag, "_m_eop"},   64'(m_eop),      64'd0);
        check({tag, "_m_len"},   64'(m_len),      64'd0);
        check({tag, "_err_len"}, 64'(err_len),    64'd0);
        check({tag, "_pkt_cnt"}, 64'(pkt_cnt),    64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check_reset_outputs("rst0");
        go();
        rst = 1'b0;
        m_ready = 1'b1;

        // T1: L=3 packet A1..A3, first-beat latency and back-to-back beats
        hs_q.delete();
        r0 = rd_cnt;
        go();
        push_pkt(3, 32'hA1, 3);
        repeat (4) @(negedge clk);
        check("t1_not_yet_valid", 64'(m_valid), 64'd0);
        @(negedge clk);
        check("t1_first_valid", 64'(m_valid), 64'd1);
        check("t1_first_beat", 64'({m_sop, m_eop, m_data}), 64'({2'b10, 32'hA1}));
        drain(50);
        check("t1_m_len", 64'(m_len), 64'd3);
        check("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);
        check("t1_reads", 64'(rd_cnt - r0), 64'd4);
        check("t1_beats", 64'(hs_q.size()), 64'd3);
        check("t1_gap01", 64'(hs_q[1] - hs_q[0]), 64'd1);
        check("t1_gap12", 64'(hs_q[2] - hs_q[1]), 64'd1);

        // T2: zero-length header discarded (upper bits ignored), then L=1
        e0 = err_seen;
        go();
        push_word(32'hFFFF_0000);
        push_word(32'h0000_0001);
        push_word(32'h0000_00B0);
        exp_q.push_back({2'b11, 32'h0000_00B0});
        drain(50);
        check("t2_err_pulses", 64'(err_seen - e0), 64'd1);
        check("t2_m_len", 64'(m_len), 64'd1);
        check("t2_pkt_cnt", 64'(pkt_cnt), 64'd2);

        // T3: L=5 under backpressure: two payload reads only, head word held
        go();
        m_ready = 1'b0;
        r0 = rd_cnt;
        push_pkt(5, 32'h50, 5);
        repeat (12) @(negedge clk);
        check("t3_reads_stalled", 64'(rd_cnt - r0), 64'd3);
        check("t3_held_valid", 64'(m_valid), 64'd1);
        check("t3_held_beat", 64'({m_sop, m_eop, m_data}), 64'({2'b10, 32'h50}));
        go();
        m_ready = 1'b1;
        drain(50);
        check("t3_reads_total", 64'(rd_cnt - r0), 64'd6);
        check("t3_pkt_cnt", 64'(pkt_cnt), 64'd3);

        // T4: back-to-back L=2, L=1 with only the header overhead between them
        hs_q.delete();
        r0 = rd_cnt;
        go();
        push_pkt(2, 32'h61, 2);
        push_pkt(1, 32'h71, 1);
        drain(50);
        check("t4_pkt_cnt", 64'(pkt_cnt), 64'd5);
        check("t4_reads", 64'(rd_cnt - r0), 64'd5);
        check("t4_gap_in_pkt", 64'(hs_q[1] - hs_q[0]), 64'd1);
        check("t4_gap_across", 64'(hs_q[2] - hs_q[1]), 64'd3);

        // T5: FIFO runs dry after word 2 of L=4, then refills
        r0 = rd_cnt;
        go();
        push_pkt(4, 32'h40, 2);
        repeat (12) @(negedge clk);
        check("t5_reads_dry", 64'(rd_cnt - r0), 64'd3);
        check("t5_pending", 64'(exp_q.size()), 64'd2);
        check("t5_rd_idle", 64'(fifo_rd_en), 64'd0);
        go();
        push_word(32'h42);
        push_word(32'h43);
        drain(50);
        check("t5_reads_total", 64'(rd_cnt - r0), 64'd5);
        check("t5_pkt_cnt", 64'(pkt_cnt), 64'd6);

        // T6: reset mid-payload of L=8; the leftover FIFO word is then a header (L=1)
        go();
        m_ready = 1'b0;
        r0 = rd_cnt;
        push_word(32'h8);
        push_word(32'h81);
        push_word(32'h82);
        push_word(32'h1);
        repeat (10) @(negedge clk);
        check("t6_reads_pre", 64'(rd_cnt - r0), 64'd3);
        check("t6_valid_pre", 64'(m_valid), 64'd1);
        check("t6_len_pre", 64'(m_len), 64'd8);
        go();
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        check("t6_fifo_kept", 64'(fq.size()), 64'd1);
        go();
        rst = 1'b0;
        m_ready = 1'b1;
        push_word(32'hD0);
        exp_q.push_back({2'b11, 32'h0000_00D0});
        drain(50);
        check("t6_pkt_cnt", 64'(pkt_cnt), 64'd1);
        check("t6_m_len", 64'(m_len), 64'd1);
        check("t6_fifo_empty", 64'(fq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
